// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side types: FSM states, next-PC select codes, instruction layout, immediates.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Next-PC select encodings driven by the control unit
    localparam logic [1:0] PCS_SEQ  = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JAL  = 2'b10;
    localparam logic [1:0] PCS_JALR = 2'b11;

    // addi x0, x0, 0 -- IR contents before the first fetch completes
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, shared with the control unit's decoder
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // R-type field view of a 32-bit instruction word
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    // I-type immediate (JALR offset)
    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    // B-type immediate (conditional branch offset, always even)
    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // J-type immediate (JAL offset, always even)
    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit and IMEM.
// Latency: set by the memory; the request is a level held until ack.
// Backpressure: memory stalls by withholding ack; no data is lost while req stays high.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ack;

    // Fetch unit side
    modport master (
        output req,
        output addr,
        input  rdata,
        input  ack
    );

    // Memory side
    modport slave (
        input  req,
        input  addr,
        output rdata,
        output ack
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Combinational next-PC: sequential, conditional branch, JAL and JALR targets plus alignment flag.
// Latency: 0 cycles (pure logic on IR/PC/control inputs).
// Backpressure: none; the FSM only consumes the result in its EXEC cycle.
module next_pc_calc
    import riscv_fetch_pkg::*;
(
    input  instr_t      ir,
    input  logic [31:0] pc,
    input  logic [1:0]  pcs,
    input  logic        bs,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] word;
    logic [31:0] pc_seq;
    logic        unused_opcode;

    assign word          = ir;
    assign pc_seq        = pc + 32'd4;
    // Opcode bits carry no immediate information; the control unit decides PCS from them.
    assign unused_opcode = ^word[6:0];

    // Select the target; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_seq;
        case (pcs)
            PCS_SEQ:  next_pc = pc_seq;
            PCS_BR:   next_pc = bs ? (pc + imm_b(word)) : pc_seq;
            PCS_JAL:  next_pc = pc + imm_j(word);
            PCS_JALR: next_pc = (rs1_data + imm_i(word)) & ~32'h1;
        endcase
    end

    // Word alignment is required; JALR clears only bit 0, so bit 1 can still trip this.
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: holds PC, fetches over req/ack, latches IR, decodes fields, computes next PC.
// Latency: 1+wait cycles per fetch, then one EXEC cycle (2 cycles/instr at zero wait).
// Backpressure: req held until ack; MAX_WAIT ack-less cycles or a misaligned target -> sticky FAULT.
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               CLK,
    input  logic               RST,
    instr_fetch_unit_if.master imem,
    input  logic [1:0]         PCS,
    input  logic               BS,
    input  logic [31:0]        RS1_DATA,
    output logic [6:0]         OP_CODE,
    output logic [2:0]         FUNCT_3,
    output logic [6:0]         FUNCT_7,
    output logic [4:0]         RS1_ADDR,
    output logic [4:0]         RS2_ADDR,
    output logic [4:0]         RD_ADDR,
    output logic [31:0]        PC_OUT,
    output logic [31:0]        PC_PLUS4,
    output logic               INSTR_VALID,
    output logic               FAULT
);

    // Counter value on the last tolerated ack-less FETCH cycle
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t state;
    logic [31:0]  pc;        // address being (or about to be) fetched
    logic [31:0]  pc_ir;     // address of the instruction currently held in IR
    instr_t       ir;
    logic [7:0]   wait_cnt;
    logic         req_q;
    logic         valid_q;
    logic         fault_q;

    logic [31:0]  next_pc;
    logic         misaligned;

    // pc_ir equals pc during EXEC; using pc_ir keeps the calculator tied to IR's own address.
    next_pc_calc u_next_pc (
        .ir         (ir),
        .pc         (pc_ir),
        .pcs        (PCS),
        .bs         (BS),
        .rs1_data   (RS1_DATA),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // Fetch FSM with registered req/valid/fault; reset overrides any ack or fault this edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            pc_ir    <= RESET_PC;
            ir       <= instr_t'(NOP_INSTR);
            wait_cnt <= 8'd0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_FETCH;
                    req_q <= 1'b1;
                end

                ST_FETCH: begin
                    if (imem.ack) begin
                        ir       <= instr_t'(imem.rdata);
                        pc_ir    <= pc;
                        wait_cnt <= 8'd0;
                        req_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state    <= ST_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        req_q    <= 1'b0;
                        fault_q  <= 1'b1;
                        state    <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                ST_EXEC: begin
                    valid_q <= 1'b0;
                    if (misaligned) begin
                        fault_q <= 1'b1;
                        state   <= ST_FAULT;
                    end else begin
                        pc      <= next_pc;
                        req_q   <= 1'b1;
                        state   <= ST_FETCH;
                    end
                end

                ST_FAULT: begin
                    // Frozen until reset
                    state <= ST_FAULT;
                end

                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b1;
                    state   <= ST_FAULT;
                end
            endcase
        end
    end

    assign imem.req    = req_q;
    assign imem.addr   = pc;

    assign OP_CODE     = ir.opcode;
    assign FUNCT_3     = ir.funct3;
    assign FUNCT_7     = ir.funct7;
    assign RS1_ADDR    = ir.rs1;
    assign RS2_ADDR    = ir.rs2;
    assign RD_ADDR     = ir.rd;
    assign PC_OUT      = pc_ir;
    assign PC_PLUS4    = pc_ir + 32'd4;
    assign INSTR_VALID = valid_q;
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized instruction stream.
// Latency: inputs driven on falling edges, outputs compared 1 time unit after each rising edge.
// Backpressure: the bench plays instruction memory with random ack latency below the timeout.
module tb_instr_fetch_unit;

    localparam int MAX_WAIT = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  PCS = 2'b00;
    logic        BS = 1'b0;
    logic [31:0] RS1_DATA = 32'd0;
    logic [6:0]  OP_CODE;
    logic [2:0]  FUNCT_3;
    logic [6:0]  FUNCT_7;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [31:0] PC_OUT, PC_PLUS4;
    logic        INSTR_VALID, FAULT;

    instr_fetch_unit_if imem();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST), .imem(imem),
        .PCS(PCS), .BS(BS), .RS1_DATA(RS1_DATA),
        .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3), .FUNCT_7(FUNCT_7),
        .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
        .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4),
        .INSTR_VALID(INSTR_VALID), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Architectural model: PC to fetch next, instruction word held, and its address
    logic [31:0] m_pc, m_ir, m_irpc;
    // Expected DUT outputs after the next rising edge
    logic        exp_req, exp_valid, exp_fault;
    logic [31:0] exp_addr, exp_ir, exp_pcout;
    int          t_exec = 0, t_exec_prev = 0;
    logic [31:0] exec_pp4;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Per-cycle comparison against the model's expectation
    always @(posedge CLK) begin
        #1;
        if (chk_en) begin
            chk("imem_req",    {31'd0, imem.req}, {31'd0, exp_req});
            chk("imem_addr",   imem.addr, exp_addr);
            chk("instr_valid", {31'd0, INSTR_VALID}, {31'd0, exp_valid});
            chk("fault",       {31'd0, FAULT}, {31'd0, exp_fault});
            chk("op_code",     {25'd0, OP_CODE}, {25'd0, exp_ir[6:0]});
            chk("funct_3",     {29'd0, FUNCT_3}, {29'd0, exp_ir[14:12]});
            chk("funct_7",     {25'd0, FUNCT_7}, {25'd0, exp_ir[31:25]});
            chk("rs1_addr",    {27'd0, RS1_ADDR}, {27'd0, exp_ir[19:15]});
            chk("rs2_addr",    {27'd0, RS2_ADDR}, {27'd0, exp_ir[24:20]});
            chk("rd_addr",     {27'd0, RD_ADDR}, {27'd0, exp_ir[11:7]});
            chk("pc_out",      PC_OUT, exp_pcout);
            chk("pc_plus4",    PC_PLUS4, exp_pcout + 32'd4);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic set_common();
        exp_addr  = m_pc;
        exp_ir    = m_ir;
        exp_pcout = m_irpc;
    endtask
    task automatic set_idle();
        exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0; set_common();
    endtask
    task automatic set_fetch();
        exp_req = 1'b1; exp_valid = 1'b0; exp_fault = 1'b0; set_common();
    endtask
    task automatic set_exec();
        exp_req = 1'b0; exp_valid = 1'b1; exp_fault = 1'b0; set_common();
    endtask
    task automatic set_fault();
        exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b1; set_common();
    endtask

    // Instruction encoders: place a chosen immediate into an otherwise random word
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] fill);
        logic [31:0] w = fill;
        w[31] = imm[12]; w[30:25] = imm[10:5]; w[11:8] = imm[4:1]; w[7] = imm[11];
        w[6:0] = 7'b1100011;
        return w;
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] fill);
        logic [31:0] w = fill;
        w[31] = imm[20]; w[30:21] = imm[10:1]; w[20] = imm[11]; w[19:12] = imm[19:12];
        w[6:0] = 7'b1101111;
        return w;
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] fill);
        logic [31:0] w = fill;
        w[31:20] = imm[11:0]; w[6:0] = 7'b1100111;
        return w;
    endfunction

    // Hold reset n cycles (random ack during it), release, pass the boot cycle into FETCH
    task automatic do_reset(input int n, input logic boot_ack);
        RST = 1'b1;
        m_pc = 32'd0; m_ir = NOP; m_irpc = 32'd0;
        set_idle();
        for (int i = 0; i < n; i++) begin
            imem.ack = 1'($urandom); imem.rdata = $urandom;
            tick();
        end
        RST = 1'b0; imem.ack = boot_ack; imem.rdata = $urandom;
        set_fetch();
        tick();
        imem.ack = 1'b0;
    endtask

    // One instruction: lat ack-less cycles, ack with instr, then EXEC with the given controls
    task automatic do_instr(input logic [31:0] instr, input int lat, input logic [1:0] pcs,
                            input logic bs, input logic [31:0] rs1, input logic [31:0] nxt);
        for (int i = 0; i < lat; i++) begin
            imem.ack = 1'b0; imem.rdata = $urandom;
            set_fetch();
            tick();
        end
        imem.ack = 1'b1; imem.rdata = instr;
        m_ir = instr; m_irpc = m_pc;
        set_exec();
        tick();
        t_exec_prev = t_exec; t_exec = cyc; exec_pp4 = PC_PLUS4;
        imem.ack = 1'($urandom); imem.rdata = $urandom;
        PCS = pcs; BS = bs; RS1_DATA = rs1;
        if (nxt[1:0] != 2'b00) begin
            set_fault();
        end else begin
            m_pc = nxt;
            set_fetch();
        end
        tick();
        imem.ack = 1'b0; PCS = 2'($urandom); BS = 1'($urandom); RS1_DATA = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imm, t, rs1, instr;
        logic [1:0]  pcs;
        logic        bs;
        int          lat;

        imem.ack = 1'b0; imem.rdata = 32'd0;
        m_pc = 32'd0; m_ir = NOP; m_irpc = 32'd0;
        set_idle();
        chk_en = 1'b1;

        // Reset held two cycles
        tick();
        chk("rst_req", {31'd0, imem.req}, 32'd0);
        chk("rst_opcode", {25'd0, OP_CODE}, 32'h13);
        chk("rst_fault", {31'd0, FAULT}, 32'd0);
        tick();
        RST = 1'b0; set_fetch(); tick();
        chk("boot_addr", imem.addr, 32'h0);
        chk("boot_req", {31'd0, imem.req}, 32'd1);

        // Sequential, latency 0, 0, 3
        do_instr($urandom, 0, 2'b00, 1'b0, $urandom, m_pc + 32'd4);
        chk("seq_addr1", imem.addr, 32'h4);
        do_instr($urandom, 0, 2'b00, 1'b1, $urandom, m_pc + 32'd4);
        chk("seq_addr2", imem.addr, 32'h8);
        chk("gap_zero_wait", t_exec - t_exec_prev, 32'd2);
        do_instr($urandom, 3, 2'b00, 1'b0, $urandom, m_pc + 32'd4);
        chk("gap_wait3", t_exec - t_exec_prev, 32'd5);
        do_instr($urandom, 1, 2'b00, 1'b0, $urandom, m_pc + 32'd4);
        chk("seq_addr4", imem.addr, 32'h10);

        // Branch at 0x10 with +8: taken, jump back, not taken
        do_instr(enc_b(32'd8, $urandom), 0, 2'b01, 1'b1, $urandom, m_pc + 32'd8);
        chk("br_taken", imem.addr, 32'h18);
        do_instr(enc_j(-32'sd8, $urandom), 2, 2'b10, 1'b0, $urandom, m_pc - 32'd8);
        chk("jal_back", imem.addr, 32'h10);
        do_instr(enc_b(32'd8, $urandom), 1, 2'b01, 1'b0, $urandom, m_pc + 32'd4);
        chk("br_not_taken", imem.addr, 32'h14);

        // JAL to 0x40, then JAL -16 from 0x40
        do_instr(enc_j(32'h2C, $urandom), 0, 2'b10, 1'b1, $urandom, m_pc + 32'h2C);
        chk("jal_fwd", imem.addr, 32'h40);
        do_instr(enc_j(-32'sd16, $urandom), 0, 2'b10, 1'b0, $urandom, m_pc - 32'd16);
        chk("jal_pc_plus4", exec_pp4, 32'h44);
        chk("jal_target", imem.addr, 32'h30);

        // JALR to 0x103+0 -> 0x102: misaligned, sticky fault
        do_instr(enc_i(32'd0, $urandom), 0, 2'b11, 1'b0, 32'h103, (32'h103 + 32'd0) & ~32'h1);
        for (int i = 0; i < 3; i++) begin
            imem.ack = 1'($urandom); set_fault(); tick();
        end
        chk("jalr_fault", {31'd0, FAULT}, 32'd1);
        chk("jalr_req", {31'd0, imem.req}, 32'd0);
        chk("jalr_pc_out", PC_OUT, 32'h30);

        // Fetch timeout after MAX_WAIT ack-less cycles
        do_reset(1, 1'b0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            imem.ack = 1'b0;
            if (i == MAX_WAIT - 1) set_fault(); else set_fetch();
            tick();
        end
        chk("timeout_fault", {31'd0, FAULT}, 32'd1);

        // Reset mid-FETCH, ack on the reset edge and in the boot cycle are both ignored
        do_reset(2, 1'b0);
        do_instr($urandom, 0, 2'b00, 1'b0, $urandom, m_pc + 32'd4);
        RST = 1'b1; imem.ack = 1'b1; imem.rdata = $urandom;
        m_pc = 32'd0; m_ir = NOP; m_irpc = 32'd0;
        set_idle(); tick();
        chk("rst_mid_req", {31'd0, imem.req}, 32'd0);
        RST = 1'b0; imem.ack = 1'b1; imem.rdata = 32'hFFFF_FFFF;
        set_fetch(); tick();
        imem.ack = 1'b0;
        chk("rst_refetch_addr", imem.addr, 32'h0);
        chk("rst_late_ack_ir", {25'd0, OP_CODE}, 32'h13);

        // Randomized instruction stream, always aligned targets
        for (int n = 0; n < 300; n++) begin
            lat = $urandom_range(0, MAX_WAIT - 1);
            pcs = 2'($urandom);
            bs  = 1'($urandom);
            rs1 = $urandom;
            case (pcs)
                2'b00: begin
                    instr = $urandom;
                    t = m_pc + 32'd4;
                end
                2'b01: begin
                    imm = 32'(($urandom_range(0, 2047) - 1024) * 4);
                    instr = enc_b(imm, $urandom);
                    t = bs ? m_pc + imm : m_pc + 32'd4;
                end
                2'b10: begin
                    imm = 32'(($urandom_range(0, 262143) - 131072) * 4);
                    instr = enc_j(imm, $urandom);
                    t = m_pc + imm;
                end
                default: begin
                    imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                    instr = enc_i(imm, $urandom);
                    t = $urandom & ~32'h3;
                    rs1 = t - imm + 32'($urandom_range(0, 1));
                end
            endcase
            do_instr(instr, lat, pcs, bs, rs1, t);
        end

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
